// File: rtl/timer_ctrl.sv
// Interval timer controller: config capture, IDLE/RUN/DONE sequencing and counter load/reload.
// Optional sticky interrupt (irq/irq_clr) enabled by defining TIMER_CTRL_IRQ_STICKY_EN.
module timer_ctrl #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_period,
    input  logic             cfg_oneshot,
    input  logic             start,
    input  logic             stop,
    output logic             busy,
    output logic             done,
    output logic             tick,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] tick_cnt
`ifdef TIMER_CTRL_IRQ_STICKY_EN
    ,
    input  logic             irq_clr,
    output logic             irq
`endif
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] tick_cnt_q, tick_cnt_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             oneshot_q, oneshot_d;
    logic             cfg_fire;

    assign cfg_ready = (state_q != ST_RUN);
    assign busy      = (state_q == ST_RUN);
    assign done      = (state_q == ST_DONE);
    assign tick      = (state_q == ST_RUN) && (count_q == '0);
    assign count     = count_q;
    assign tick_cnt  = tick_cnt_q;
    assign cfg_fire  = cfg_valid && cfg_ready;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        tick_cnt_d = tick_cnt_q;
        period_d   = period_q;
        oneshot_d  = oneshot_q;

        if (cfg_fire) begin
            period_d  = cfg_period;
            oneshot_d = cfg_oneshot;
        end

        // Every expiry is counted, even when stop or restart wins the same cycle.
        if (tick) begin
            tick_cnt_d = tick_cnt_q + 1'b1;
        end

        case (state_q)
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (start) begin
                    count_d = period_q;
                end else if (tick) begin
                    if (oneshot_q) begin
                        state_d = ST_DONE;
                    end else begin
                        count_d = period_q;
                    end
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
            default: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (start) begin
                    // period_d already reflects a same-cycle config handshake.
                    state_d    = ST_RUN;
                    count_d    = period_d;
                    tick_cnt_d = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            tick_cnt_q <= '0;
            period_q   <= '0;
            oneshot_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            tick_cnt_q <= tick_cnt_d;
            period_q   <= period_d;
            oneshot_q  <= oneshot_d;
        end
    end

`ifdef TIMER_CTRL_IRQ_STICKY_EN
    logic irq_q, irq_d;

    always_comb begin
        irq_d = irq_q;
        if (tick) begin
            irq_d = 1'b1;
        end else if (irq_clr) begin
            irq_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq = irq_q;
`endif

endmodule

// File: doc/timer_ctrl.md
Name: timer_ctrl

Overview:
- Programmable interval timer controller that sequences a loadable 4-bit down-counter datapath.
- Accepts a period and mode over a valid/ready config port, runs the counter, and emits a one-cycle tick on expiry.
- Supports periodic auto-reload and one-shot modes.
- Sits between control logic and the counter datapath; owns all load/reload decisions.

Parameters:
- WIDTH, 4, width of period, count and tick-count paths.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- cfg_valid  input  1  config request.
- cfg_ready  output  1  controller can accept config.
- cfg_period  input  WIDTH  reload value P; interval is P+1 cycles.
- cfg_oneshot  input  1  1 = stop after first expiry, 0 = auto-reload.
- start  input  1  begin/restart timing.
- stop  input  1  abort timing.
- busy  output  1  high in RUN.
- done  output  1  high in DONE (one-shot expired).
- tick  output  1  one-cycle expiry pulse.
- count  output  WIDTH  current counter value.
- tick_cnt  output  WIDTH  expiries since last start, wraps.

Behaviour:
- Reset (async, reset_n=0): state IDLE; count=0, tick_cnt=0, period_q=0, oneshot_q=0; busy=0, done=0, tick=0, cfg_ready=1.
- States: IDLE, RUN, DONE. cfg_ready = (state != RUN).
- Config: on cfg_valid & cfg_ready, capture period_q<=cfg_period, oneshot_q<=cfg_oneshot. cfg_valid in RUN is not accepted and is held off by cfg_ready=0.
- IDLE/DONE + start: next cycle RUN, count<=P, tick_cnt<=0. If a config handshake happens in the same cycle, the new P and mode are used.
- RUN: count decrements by 1 each cycle.
- tick is combinational: tick = (state==RUN) & (count==0).
- On tick in periodic mode: count<=P, tick_cnt++ (wraps 2^WIDTH-1 -> 0), stay RUN.
- On tick in one-shot mode: tick_cnt++, next state DONE, count holds 0.
- RUN + stop: next state IDLE, count holds its current value. stop has priority over start and reload. If tick is high in the same cycle, tick still pulses and tick_cnt still increments.
- RUN + start (no stop): restart, count<=P, tick_cnt unchanged. If count==0 in the same cycle, tick still pulses.
- P=0: tick every cycle in periodic mode; one-shot ticks in the first RUN cycle.
- DONE: done=1. Leaves only on start (-> RUN) or stop (-> IDLE).
- Reset mid-RUN: immediate return to reset values; no tick.

Optional Feature:
- Macro: TIMER_CTRL_IRQ_STICKY_EN.
- Defined: adds input irq_clr (1) and output irq (1). irq sets on tick and stays high until irq_clr. If tick and irq_clr occur in the same cycle, set wins. Reset value 0.
- Undefined: ports absent; only the one-cycle tick is provided.

Test Plan:
- Reset then cfg P=3, periodic, start -> count 3,2,1,0,3...; tick at every 4th RUN cycle; tick_cnt 1,2,3 after 12 cycles.
- cfg P=2, one-shot, start -> single tick on 3rd RUN cycle, then done=1, busy=0, count=0, tick_cnt=1, cfg_ready=1.
- Periodic P=5, stop asserted when count=2 -> IDLE next cycle, count holds 2, no further ticks; start -> count reloads 5.
- Start and stop asserted together in RUN at count=0 -> tick=1 that cycle, tick_cnt increments, state IDLE next cycle.
- P=0 periodic for 17 cycles -> tick high every cycle, tick_cnt wraps 15 -> 0; cfg_valid during RUN not accepted (period_q unchanged).
- With TIMER_CTRL_IRQ_STICKY_EN: tick and irq_clr in the same cycle -> irq=1; irq_clr alone afterwards -> irq=0.
